// File: rtl/nasti_stream_mover_arbiter.sv
// nasti_stream_mover_arbiter: round-robin sharing of one NASTI->NASTI-Stream mover between NUM_REQ requesters.
// Build option STREAM_MOVER_ARB_STATS_EN adds the stat_xfers/stat_bytes completion counters.
//
//  state | meaning
//  IDLE  | arbitrate; the round-robin winner is accepted this cycle
//  ISSUE | m_valid held with latched m_src/m_len until the mover takes it
//  WAIT  | mover busy; wait for m_ready to return high
//  DONE  | done pulse to the owner; rr pointer moves to the owner
module nasti_stream_mover_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_src,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]            done,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [ADDR_WIDTH-1:0]         m_src,
  output logic [ADDR_WIDTH-1:0]         m_len,
  output logic                          m_valid,
  input  logic                          m_ready
`ifdef STREAM_MOVER_ARB_STATS_EN
  ,
  output logic [31:0]                   stat_xfers,
  output logic [63:0]                   stat_bytes
`endif
);

  localparam int IDW        = $clog2(NUM_REQ);
  localparam int ADDR_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = {ADDR_WIDTH{1'b1}} << ADDR_SHIFT;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDW-1:0]          last_q, last_d;
  logic [IDW-1:0]          grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   src_q, src_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;
  logic                    mvalid_q, mvalid_d;
  logic [NUM_REQ-1:0]      done_q, done_d;

  logic [ADDR_WIDTH-1:0]   src_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0]   len_arr [NUM_REQ];
  logic                    win_found;
  logic [IDW-1:0]          win_id;
  logic [IDW-1:0]          cand;

  // Beat-align at the input so the mover never sees a partial beat.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      src_arr[i] = req_src[i*ADDR_WIDTH +: ADDR_WIDTH] & BEAT_MASK;
      len_arr[i] = req_len[i*ADDR_WIDTH +: ADDR_WIDTH] & BEAT_MASK;
    end
  end

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(last_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    src_d     = src_q;
    len_d     = len_q;
    mvalid_d  = mvalid_q;
    done_d    = '0;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          req_ready[win_id] = 1'b1;
          grant_d           = win_id;
          src_d             = src_arr[win_id];
          len_d             = len_arr[win_id];
          if (len_arr[win_id] == '0) begin
            state_d        = S_DONE;
            done_d[win_id] = 1'b1;
          end else begin
            state_d  = S_ISSUE;
            mvalid_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (m_ready) begin
          mvalid_d = 1'b0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (m_ready) begin
          state_d         = S_DONE;
          done_d[grant_q] = 1'b1;
        end
      end
      S_DONE: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      last_q   <= IDW'(NUM_REQ - 1);
      grant_q  <= '0;
      src_q    <= '0;
      len_q    <= '0;
      mvalid_q <= 1'b0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      src_q    <= src_d;
      len_q    <= len_d;
      mvalid_q <= mvalid_d;
      done_q   <= done_d;
    end
  end

  assign m_src    = src_q;
  assign m_len    = len_q;
  assign m_valid  = mvalid_q;
  assign done     = done_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != S_IDLE);

`ifdef STREAM_MOVER_ARB_STATS_EN
  logic [31:0] xfers_q, xfers_d;
  logic [63:0] bytes_q, bytes_d;

  // Zero-length requests bypass the mover and are not counted.
  always_comb begin
    xfers_d = xfers_q;
    bytes_d = bytes_q;
    if (state_q == S_DONE && len_q != '0) begin
      xfers_d = xfers_q + 32'd1;
      bytes_d = bytes_q + 64'(len_q);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      xfers_q <= '0;
      bytes_q <= '0;
    end else begin
      xfers_q <= xfers_d;
      bytes_q <= bytes_d;
    end
  end

  assign stat_xfers = xfers_q;
  assign stat_bytes = bytes_q;
`endif

endmodule
